// File: rtl/tiny_dnn_layer_seq_if.sv
// tiny_dnn_layer_seq_if: host/config/control bundle between the host, the layer sequencer and the datapath.
interface tiny_dnn_layer_seq_if #(
  parameter int AW = 3,
  parameter int DESC_W = 82
);
  logic cfg_we;
  logic [AW-1:0] cfg_addr;
  logic [DESC_W-1:0] cfg_data;
  logic [AW:0] num_layers;
  logic start, abort, layer_done;
  logic busy, done;
  logic [AW-1:0] layer_idx;
  logic run, backprop, deltaw, enbias, last;
  logic [3:0] id, od;
  logic [9:0] is, os, fs, ks;
  logic [4:0] ih, iw, oh, ow, kh, kw;
  modport master (
    output cfg_we, cfg_addr, cfg_data, num_layers, start, abort, layer_done,
    input busy, done, layer_idx, run, backprop, deltaw, enbias, last,
    input id, od, is, os, fs, ks, ih, iw, oh, ow, kh, kw
  );
  modport slave (
    input cfg_we, cfg_addr, cfg_data, num_layers, start, abort, layer_done,
    output busy, done, layer_idx, run, backprop, deltaw, enbias, last,
    output id, od, is, os, fs, ks, ih, iw, oh, ow, kh, kw
  );
endinterface

// File: rtl/tiny_dnn_layer_seq.sv
// tiny_dnn_layer_seq: walks a host-written layer descriptor table, driving run/mode/shape per layer; LAYER_SEQ_PERF_EN adds run-cycle counters.
module tiny_dnn_layer_seq #(
  parameter int N_LAYER = 8,
  parameter int AW = 3,
  parameter int GAP = 2,
  parameter int DESC_W = 82
) (
  input logic clk,
  input logic rst,
  tiny_dnn_layer_seq_if.slave bus
`ifdef LAYER_SEQ_PERF_EN
  ,
  output logic [31:0] run_cyc,
  output logic [31:0] layer_cyc
`endif
);
  typedef enum logic [2:0] {IDLE, SETUP, RUN, DRAIN, FIN} state_t;
  state_t state, nxt;
  logic [DESC_W-1:0] tbl [N_LAYER];
  logic [DESC_W-1:0] cfg_q, desc;
  logic [AW:0] cnt, nl;
  logic [AW-1:0] idx, ld_idx;
  logic [7:0] gap;
  logic go, wr, more;
  assign nl = (bus.num_layers > (AW+1)'(N_LAYER)) ? (AW+1)'(N_LAYER) : bus.num_layers;
  assign go = state == IDLE && bus.start;
  assign wr = state == IDLE && bus.cfg_we;
  assign more = ({1'b0, idx} + (AW+1)'(1)) < cnt;
  assign ld_idx = go ? '0 : idx + AW'(1);
  // write-first so a start alongside a write to the first entry sees the new descriptor
  assign desc = (wr && bus.cfg_addr == ld_idx) ? bus.cfg_data : tbl[ld_idx];
  always_ff @(posedge clk)
    if (wr) tbl[bus.cfg_addr] <= bus.cfg_data;
  always_ff @(posedge clk)
    state <= rst ? IDLE : nxt;
  always_comb begin
    nxt = state;
    case (state)
      IDLE: nxt = bus.start ? (nl == '0 ? FIN : SETUP) : IDLE;
      SETUP: nxt = RUN;
      RUN: nxt = bus.layer_done ? DRAIN : RUN;
      DRAIN: nxt = gap == 8'(GAP-1) ? (more ? SETUP : FIN) : DRAIN;
      FIN: nxt = IDLE;
      default: nxt = IDLE;
    endcase
    if (bus.abort && state != IDLE) nxt = IDLE;
  end
  always_ff @(posedge clk)
    if (rst) begin
      cfg_q <= '0;
      idx <= '0;
      cnt <= '0;
      gap <= '0;
    end else begin
      if (go) cnt <= nl;
      if (nxt == SETUP) begin
        idx <= ld_idx;
        cfg_q <= desc;
      end
      gap <= state == DRAIN ? gap + 8'd1 : 8'd0;
    end
  always_comb begin
    bus.busy = state == SETUP || state == RUN || state == DRAIN;
    bus.done = state == FIN;
    bus.run = state == RUN;
    bus.layer_idx = idx;
    bus.backprop = cfg_q[81:80] == 2'b01 || cfg_q[81:80] == 2'b10;
    bus.deltaw = cfg_q[81:80] == 2'b10;
    bus.enbias = cfg_q[79];
    bus.last = cfg_q[78];
    bus.id = cfg_q[77:74];
    bus.is = cfg_q[73:64];
    bus.ih = cfg_q[63:59];
    bus.iw = cfg_q[58:54];
    bus.od = cfg_q[53:50];
    bus.os = cfg_q[49:40];
    bus.oh = cfg_q[39:35];
    bus.ow = cfg_q[34:30];
    bus.fs = cfg_q[29:20];
    bus.ks = cfg_q[19:10];
    bus.kh = cfg_q[9:5];
    bus.kw = cfg_q[4:0];
  end
`ifdef LAYER_SEQ_PERF_EN
  logic [31:0] lay;
  always_ff @(posedge clk)
    if (rst) begin
      run_cyc <= '0;
      layer_cyc <= '0;
      lay <= '0;
    end else begin
      if (go) run_cyc <= '0;
      else if (state == RUN && run_cyc != '1) run_cyc <= run_cyc + 32'd1;
      lay <= state == RUN ? lay + 32'd1 : 32'd0;
      if (state == RUN && nxt == DRAIN) layer_cyc <= lay + 32'd1;
    end
`endif
endmodule

// File: tb/tb_tiny_dnn_layer_seq.sv
// tb_tiny_dnn_layer_seq: directed self-checking bench for the layer sequencer.
module tb_tiny_dnn_layer_seq;
  localparam int AW = 3;
  localparam int DW = 82;
  localparam int GAP = 2;
  logic clk = 1'b0;
  logic rst;
  int checks = 0;
  int errors = 0;
  tiny_dnn_layer_seq_if #(.AW(AW), .DESC_W(DW)) bus ();
`ifdef LAYER_SEQ_PERF_EN
  logic [31:0] run_cyc, layer_cyc;
`endif
  tiny_dnn_layer_seq #(.N_LAYER(8), .AW(AW), .GAP(GAP), .DESC_W(DW)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
`ifdef LAYER_SEQ_PERF_EN
    ,
    .run_cyc(run_cyc),
    .layer_cyc(layer_cyc)
`endif
  );
  always #5 clk = ~clk;
  function automatic logic [DW-1:0] mk(input logic [1:0] m, input int v);
    return {m, v[0], v[1], 4'(v), 10'(v*3), 5'(v+1), 5'(v+2), 4'(v+3), 10'(v*5),
            5'(v+4), 5'(v+5), 10'(v*7), 10'(v*11), 5'(v+6), 5'(v+7)};
  endfunction
  task automatic step;
    @(posedge clk);
    #1;
  endtask
  task automatic wr(input int a, input logic [DW-1:0] d);
    bus.cfg_we = 1'b1;
    bus.cfg_addr = AW'(a);
    bus.cfg_data = d;
    step;
    bus.cfg_we = 1'b0;
  endtask
  task automatic kick(input int n);
    bus.num_layers = (AW+1)'(n);
    bus.start = 1'b1;
    step;
    bus.start = 1'b0;
  endtask
  task automatic finish_layer;
    bus.layer_done = 1'b1;
    step;
    bus.layer_done = 1'b0;
    repeat (GAP) step;
  endtask
  task automatic test_reset;
    rst = 1'b1;
    repeat (3) step;
    checks++;
    if ({bus.busy, bus.done, bus.run, bus.backprop, bus.deltaw} !== 5'b0) begin
      errors++;
      $display("FAIL reset_ctl got %b want 00000", {bus.busy, bus.done, bus.run, bus.backprop, bus.deltaw});
    end
    checks++;
    if ({bus.layer_idx, bus.kw, bus.is, bus.id} !== '0) begin
      errors++;
      $display("FAIL reset_cfg idx %0d kw %0d is %0d id %0d want 0", bus.layer_idx, bus.kw, bus.is, bus.id);
    end
    rst = 1'b0;
    step;
    checks++;
    if ({bus.busy, bus.done, bus.run} !== 3'b0) begin
      errors++;
      $display("FAIL reset_idle got %b want 000", {bus.busy, bus.done, bus.run});
    end
  endtask
  task automatic test_three_layers;
    int rc, dones;
    logic [1:0] exp;
    wr(0, mk(2'd0, 1));
    wr(1, mk(2'd1, 2));
    wr(2, mk(2'd2, 3));
    kick(3);
    dones = 0;
    for (int l = 0; l < 3; l++) begin
      exp = (l == 0) ? 2'b00 : (l == 1) ? 2'b10 : 2'b11;
      checks++;
      if ({bus.busy, bus.run} !== 2'b10 || bus.layer_idx !== AW'(l)) begin
        errors++;
        $display("FAIL setup%0d busy/run %b idx %0d want 10 idx %0d", l, {bus.busy, bus.run}, bus.layer_idx, l);
      end
      checks++;
      if (bus.kw !== 5'(l+8) || bus.is !== 10'((l+1)*3) || {bus.backprop, bus.deltaw} !== exp) begin
        errors++;
        $display("FAIL cfg%0d kw %0d is %0d mode %b want %0d %0d %b", l, bus.kw, bus.is, {bus.backprop, bus.deltaw}, l+8, (l+1)*3, exp);
      end
      step;
      rc = 1;
      repeat (19) begin
        step;
        if (bus.run) rc++;
        if (bus.done) dones++;
      end
      checks++;
      if (rc !== 20 || bus.kw !== 5'(l+8)) begin
        errors++;
        $display("FAIL run%0d high %0d kw %0d want 20 %0d", l, rc, bus.kw, l+8);
      end
      bus.layer_done = 1'b1;
      step;
      bus.layer_done = 1'b0;
      checks++;
      if ({bus.busy, bus.run} !== 2'b10) begin
        errors++;
        $display("FAIL drain%0d busy/run %b want 10", l, {bus.busy, bus.run});
      end
      repeat (GAP - 1) step;
      checks++;
      if (bus.run !== 1'b0 || bus.done !== 1'b0) begin
        errors++;
        $display("FAIL gap%0d run %b done %b want 0 0", l, bus.run, bus.done);
      end
      step;
    end
    checks++;
    if ({bus.done, bus.busy, bus.run} !== 3'b100 || dones !== 0 || bus.kw !== 5'd10) begin
      errors++;
      $display("FAIL fin3 dbr %b early_dones %0d kw %0d want 100 0 10", {bus.done, bus.busy, bus.run}, dones, bus.kw);
    end
    step;
    checks++;
    if ({bus.done, bus.busy, bus.run} !== 3'b000) begin
      errors++;
      $display("FAIL idle3 dbr %b want 000", {bus.done, bus.busy, bus.run});
    end
  endtask
  task automatic test_zero_layers;
    kick(0);
    checks++;
    if ({bus.done, bus.busy, bus.run} !== 3'b100) begin
      errors++;
      $display("FAIL zero_fin dbr %b want 100", {bus.done, bus.busy, bus.run});
    end
    step;
    checks++;
    if ({bus.done, bus.busy, bus.run} !== 3'b000) begin
      errors++;
      $display("FAIL zero_idle dbr %b want 000", {bus.done, bus.busy, bus.run});
    end
  endtask
  task automatic test_clamp;
    logic [1:0] exp;
    for (int i = 0; i < 8; i++) wr(i, mk(2'(i), i + 10));
    kick(12);
    for (int i = 0; i < 8; i++) begin
      exp = {(i % 4 == 1) || (i % 4 == 2), i % 4 == 2};
      checks++;
      if (bus.layer_idx !== AW'(i) || {bus.backprop, bus.deltaw} !== exp || bus.busy !== 1'b1) begin
        errors++;
        $display("FAIL clamp_setup%0d idx %0d mode %b busy %b want %0d %b 1", i, bus.layer_idx, {bus.backprop, bus.deltaw}, bus.busy, i, exp);
      end
      step;
      finish_layer;
    end
    checks++;
    if ({bus.done, bus.busy} !== 2'b10) begin
      errors++;
      $display("FAIL clamp_fin done/busy %b want 10", {bus.done, bus.busy});
    end
    step;
  endtask
  task automatic test_abort;
    kick(3);
    step;
    finish_layer;
    checks++;
    if (bus.layer_idx !== AW'(1)) begin
      errors++;
      $display("FAIL abort_l1 idx %0d want 1", bus.layer_idx);
    end
    step;
    bus.abort = 1'b1;
    bus.layer_done = 1'b1;
    step;
    bus.abort = 1'b0;
    bus.layer_done = 1'b0;
    checks++;
    if ({bus.busy, bus.run, bus.done} !== 3'b000) begin
      errors++;
      $display("FAIL abort_now brd %b want 000", {bus.busy, bus.run, bus.done});
    end
    repeat (2) step;
    checks++;
    if ({bus.busy, bus.run, bus.done} !== 3'b000) begin
      errors++;
      $display("FAIL abort_after brd %b want 000", {bus.busy, bus.run, bus.done});
    end
    kick(1);
    checks++;
    if (bus.busy !== 1'b1 || bus.layer_idx !== AW'(0) || bus.kw !== 5'd17) begin
      errors++;
      $display("FAIL abort_restart busy %b idx %0d kw %0d want 1 0 17", bus.busy, bus.layer_idx, bus.kw);
    end
    step;
    finish_layer;
    checks++;
    if (bus.done !== 1'b1) begin
      errors++;
      $display("FAIL abort_restart_done got %b want 1", bus.done);
    end
    step;
  endtask
  task automatic test_ignored;
    bus.cfg_we = 1'b1;
    bus.cfg_addr = '0;
    bus.cfg_data = mk(2'd1, 40);
    kick(2);
    bus.cfg_we = 1'b0;
    checks++;
    if (bus.kw !== 5'd15 || {bus.backprop, bus.deltaw} !== 2'b10) begin
      errors++;
      $display("FAIL write_first kw %0d mode %b want 15 10", bus.kw, {bus.backprop, bus.deltaw});
    end
    bus.layer_done = 1'b1;
    step;
    bus.layer_done = 1'b0;
    checks++;
    if (bus.run !== 1'b1) begin
      errors++;
      $display("FAIL done_in_setup run %b want 1", bus.run);
    end
    bus.start = 1'b1;
    bus.cfg_we = 1'b1;
    bus.cfg_addr = AW'(1);
    bus.cfg_data = mk(2'd0, 60);
    step;
    bus.start = 1'b0;
    bus.cfg_we = 1'b0;
    checks++;
    if ({bus.busy, bus.run} !== 2'b11 || bus.layer_idx !== AW'(0)) begin
      errors++;
      $display("FAIL start_busy busy/run %b idx %0d want 11 0", {bus.busy, bus.run}, bus.layer_idx);
    end
    bus.layer_done = 1'b1;
    repeat (GAP + 1) step;
    bus.layer_done = 1'b0;
    checks++;
    if (bus.layer_idx !== AW'(1) || bus.run !== 1'b0 || bus.kw !== 5'd18) begin
      errors++;
      $display("FAIL drain_ign idx %0d run %b kw %0d want 1 0 18", bus.layer_idx, bus.run, bus.kw);
    end
    step;
    checks++;
    if (bus.run !== 1'b1) begin
      errors++;
      $display("FAIL l1_run got %b want 1", bus.run);
    end
    finish_layer;
    checks++;
    if ({bus.done, bus.busy} !== 2'b10) begin
      errors++;
      $display("FAIL ign_fin done/busy %b want 10", {bus.done, bus.busy});
    end
    step;
  endtask
`ifdef LAYER_SEQ_PERF_EN
  task automatic test_perf;
    kick(2);
    step;
    repeat (14) step;
    finish_layer;
    step;
    repeat (6) step;
    finish_layer;
    checks++;
    if (layer_cyc !== 32'd7 || run_cyc !== 32'd22) begin
      errors++;
      $display("FAIL perf layer_cyc %0d run_cyc %0d want 7 22", layer_cyc, run_cyc);
    end
    step;
  endtask
`endif
  initial begin
    rst = 1'b1;
    bus.cfg_we = 1'b0;
    bus.cfg_addr = '0;
    bus.cfg_data = '0;
    bus.num_layers = '0;
    bus.start = 1'b0;
    bus.abort = 1'b0;
    bus.layer_done = 1'b0;
    test_reset;
    test_three_layers;
    test_zero_layers;
    test_clamp;
    test_abort;
    test_ignored;
`ifdef LAYER_SEQ_PERF_EN
    test_perf;
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
